thread_dispatch_scheduler: RTL and testbench
============================================

Name: thread_dispatch_scheduler

Overview:
Per-cycle scheduler for the 4-thread / 3-ALU core.
- Each cycle it picks up to NUM_ALUs eligible hardware threads and binds each one to a free ALU.
- Its output is the dispatch_threads vector that the core's ALU lanes and the IPC instrumentation consume.
- Sits between the per-thread decode/hazard stage and the ALU issue stage.
- Arbitration is round-robin, with starvation promotion and a global freeze.

Parameters:
- NUM_THREADS, 4, number of hardware threads.
- NUM_ALUS, 3, number of ALU lanes.
- TID_W, 3, thread-id width; must be at least clog2(NUM_THREADS+1). The id value NUM_THREADS encodes "lane idle".
- STARVE_LIMIT, 7, consecutive eligible-but-ungranted cycles before a thread is promoted.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- thread_valid  in  NUM_THREADS  thread has a decoded instruction ready.
- thread_hold  in  NUM_THREADS  hazard stall; thread is ineligible this cycle.
- alu_avail  in  NUM_ALUS  lane can accept an instruction.
- freeze  in  1  suppress all new grants.
- dispatch_threads  out  NUM_ALUS x TID_W  registered thread id per lane; NUM_THREADS means idle.
- grant_thread  out  NUM_THREADS  registered one-hot-per-thread grant, aligned with dispatch_threads.
- issue_count  out  clog2(NUM_ALUS+1)  registered count of non-idle lanes.

Behaviour:
- Reset (rst=1 at a clk edge):
  - every dispatch_threads lane = NUM_THREADS (4);
  - grant_thread = 0;
  - issue_count = 0;
  - rr_ptr = 0;
  - all age counters = 0;
  - state = S_RUN.
- Latency: grants computed from inputs sampled at edge N appear on the outputs after edge N (one-cycle registered latency).
- Eligibility of thread t:
  - thread_valid[t] & ~thread_hold[t] & ~grant_thread[t];
  - the grant_thread term blocks back-to-back issue from one thread, because upstream sees the grant one cycle late.
- Selection order:
  1. Promoted threads first (age == STARVE_LIMIT), ascending index.
  2. Then the remaining eligible threads in round-robin order, starting at rr_ptr and wrapping modulo NUM_THREADS.
- Lane binding:
  - the k-th selected thread goes to the k-th lowest-indexed lane with alu_avail = 1;
  - a thread is granted at most one lane per cycle;
  - unassigned lanes output NUM_THREADS.
- Grant count: min(eligible count, available-lane count), so between 0 and NUM_ALUS grants per cycle.
- rr_ptr update:
  - after a grant, rr_ptr = (highest-priority-order granted thread + 1) mod NUM_THREADS, considering round-robin grants only;
  - unchanged if there was no round-robin grant.
- Age counters:
  - increment, saturating at STARVE_LIMIT, when the thread is eligible and not granted;
  - clear on grant, or when thread_valid = 0.
- FSM states: S_RUN, S_FREEZE.
  - S_RUN to S_FREEZE when freeze = 1.
  - S_FREEZE to S_RUN when freeze = 0.
  - In S_FREEZE: all lanes idle, grant_thread = 0, rr_ptr and age counters hold.
  - The first grant after release follows the normal rules.
- Boundary conditions:
  - alu_avail = 0: no grants, ages still advance.
  - All threads eligible with 3 lanes: exactly 3 grants, and the 4th thread's age increments.
  - Simultaneous freeze and rst: rst wins.
  - rst asserted mid-operation: outputs idle on the following edge.

Optional Feature:
PERF_CNT_EN. When defined, two extra outputs are added:
- perf_cycles (32 bits): counts cycles in S_RUN.
- perf_issued (32 bits): accumulates issue_count.

Both counters saturate at 2^32-1 and are cleared by rst. When PERF_CNT_EN is undefined, the ports and counters are absent and the rest of the behaviour is identical.

Decomposition:
- Package types holds:
  - NUM_THREADS, NUM_ALUS, TID_W;
  - the IDLE_TID constant (= NUM_THREADS);
  - the sched_state_e enum {S_RUN, S_FREEZE}.
- The dispatch_threads port uses the existing NUM_ALUs constant.
- Sub-module rr_pick:
  - combinational; takes an eligible mask, a start pointer and a lane-available mask;
  - returns the lane-to-thread bindings and the next pointer.
- Ages, FSM and registers stay in the top module.

Test Plan:
1. Reset, then thread_valid=1111, hold=0, alu_avail=111 -> cycle 1: lanes {0,1,2}, grant_thread=0111, issue_count=3. Cycle 2: thread 3 only, on lane 0; lanes 1 and 2 = 4.
2. Only thread_valid=0001 held high -> grants to thread 0 on alternating cycles only (back-to-back block); issue_count toggles 1,0,1,0.
3. alu_avail=010, all threads eligible -> only lane 1 gets a thread; lanes 0 and 2 = 4. rr order across cycles follows the eligibility rules.
4. Starvation: hold thread 2 eligible while alu_avail=001 and threads 0/1 are continuously eligible, forcing losses -> thread 2 is granted no later than STARVE_LIMIT+1 cycles.
5. freeze=1 for 5 cycles mid-stream -> all lanes = 4, grant_thread=0. After release, the first grant starts at the pre-freeze rr_ptr.
6. rst during active grants, and with PERF_CNT_EN defined -> outputs idle next edge, perf_cycles/perf_issued = 0. After 10 cycles of full issue: perf_cycles=10, perf_issued matches the sum of issue_count.

Source files
------------

// File: rtl/thread_dispatch_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : thread_dispatch_scheduler_pkg
// Description : Shared sizing constants, idle-lane id and scheduler state
//               type for the 4-thread / 3-ALU dispatch scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package thread_dispatch_scheduler_pkg;

    localparam int NUM_THREADS = 4;
    localparam int NUM_ALUS    = 3;
    localparam int TID_W       = 3;

    // Round-robin pointer, lane-index and lane-count widths
    localparam int PTR_W  = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
    localparam int LANE_W = (NUM_ALUS > 1) ? $clog2(NUM_ALUS) : 1;
    localparam int CNT_W  = $clog2(NUM_ALUS + 1);

    // Thread id value that marks a lane as carrying no instruction
    localparam logic [TID_W-1:0] IDLE_TID = TID_W'(NUM_THREADS);

    typedef enum logic [0:0] {
        S_RUN    = 1'b0,
        S_FREEZE = 1'b1
    } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/thread_dispatch_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : thread_dispatch_scheduler_rr_pick
// Description : Combinational thread selector. Promoted threads are taken
//               first in ascending index, then the remaining eligible threads
//               in round-robin order from start_ptr. The k-th selected thread
//               is bound to the k-th lowest available lane.
// Revision    : 1.0 - initial release
// ============================================================================
module thread_dispatch_scheduler_rr_pick
    import thread_dispatch_scheduler_pkg::*;
(
    input  logic [NUM_THREADS-1:0]           elig,
    input  logic [NUM_THREADS-1:0]           promo,
    input  logic [PTR_W-1:0]                 start_ptr,
    input  logic [NUM_ALUS-1:0]              avail,
    output logic [NUM_ALUS-1:0][TID_W-1:0]   lane_tid,
    output logic [NUM_THREADS-1:0]           grant,
    output logic [CNT_W-1:0]                 count,
    output logic [PTR_W-1:0]                 next_ptr
);

    logic [NUM_ALUS-1:0][LANE_W-1:0] w_lane_list;
    logic [CNT_W-1:0]                w_n_avail;
    logic [CNT_W-1:0]                w_n_sel;
    logic [PTR_W-1:0]                w_t;

    // Compact available lanes, then fill them in priority order
    always_comb begin
        for (int l = 0; l < NUM_ALUS; l++) begin
            lane_tid[l]    = IDLE_TID;
            w_lane_list[l] = '0;
        end
        grant     = '0;
        next_ptr  = start_ptr;
        w_n_avail = '0;
        w_n_sel   = '0;
        w_t       = '0;

        for (int l = 0; l < NUM_ALUS; l++) begin
            if (avail[l]) begin
                w_lane_list[w_n_avail] = LANE_W'(l);
                w_n_avail              = w_n_avail + CNT_W'(1);
            end
        end

        // Starved threads bypass the round-robin pointer
        for (int i = 0; i < NUM_THREADS; i++) begin
            if (elig[i] && promo[i] && (w_n_sel < w_n_avail)) begin
                lane_tid[w_lane_list[w_n_sel]] = TID_W'(i);
                grant[i]                       = 1'b1;
                w_n_sel                        = w_n_sel + CNT_W'(1);
            end
        end

        // Pointer advances past the last round-robin winner only
        for (int j = 0; j < NUM_THREADS; j++) begin
            w_t = PTR_W'((int'(start_ptr) + j) % NUM_THREADS);
            if (elig[w_t] && !promo[w_t] && (w_n_sel < w_n_avail)) begin
                lane_tid[w_lane_list[w_n_sel]] = TID_W'(w_t);
                grant[w_t]                     = 1'b1;
                next_ptr                       = PTR_W'((int'(w_t) + 1) % NUM_THREADS);
                w_n_sel                        = w_n_sel + CNT_W'(1);
            end
        end

        count = w_n_sel;
    end

endmodule
`default_nettype wire

// File: rtl/thread_dispatch_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : thread_dispatch_scheduler
// Description : Per-cycle thread-to-ALU dispatch scheduler with round-robin
//               arbitration, starvation promotion and a global freeze.
//               Optional macro PERF_CNT_EN adds perf_cycles / perf_issued.
// Revision    : 1.0 - initial release
// ============================================================================
module thread_dispatch_scheduler
    import thread_dispatch_scheduler_pkg::*;
#(
    parameter int STARVE_LIMIT = 7
)
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_THREADS-1:0]         thread_valid,
    input  logic [NUM_THREADS-1:0]         thread_hold,
    input  logic [NUM_ALUS-1:0]            alu_avail,
    input  logic                           freeze,
    output logic [NUM_ALUS-1:0][TID_W-1:0] dispatch_threads,
    output logic [NUM_THREADS-1:0]         grant_thread,
    output logic [CNT_W-1:0]               issue_count
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]                    perf_cycles,
    output logic [31:0]                    perf_issued
`endif
);

    localparam int               AGE_W     = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0] C_AGE_MAX = AGE_W'(STARVE_LIMIT);

    sched_state_e                    r_state;
    sched_state_e                    w_state_nxt;
    logic                            w_run;
    logic [PTR_W-1:0]                r_rr_ptr;
    logic [NUM_THREADS-1:0][AGE_W-1:0] r_age;
    logic [NUM_ALUS-1:0][TID_W-1:0]  r_dispatch;
    logic [NUM_THREADS-1:0]          r_grant;
    logic [CNT_W-1:0]                r_issue_count;

    logic [NUM_THREADS-1:0]          w_elig;
    logic [NUM_THREADS-1:0]          w_promo;
    logic [NUM_ALUS-1:0][TID_W-1:0]  w_pick_lanes;
    logic [NUM_THREADS-1:0]          w_pick_grant;
    logic [CNT_W-1:0]                w_pick_count;
    logic [PTR_W-1:0]                w_pick_next_ptr;

    // Last cycle's grant blocks reissue: upstream sees the grant one cycle late
    assign w_elig = thread_valid & ~thread_hold & ~r_grant;

    genvar g;
    generate
        for (g = 0; g < NUM_THREADS; g++) begin : g_promo
            assign w_promo[g] = (r_age[g] == C_AGE_MAX);
        end
    endgenerate

    thread_dispatch_scheduler_rr_pick u_rr_pick (
        .elig      (w_elig),
        .promo     (w_promo),
        .start_ptr (r_rr_ptr),
        .avail     (alu_avail),
        .lane_tid  (w_pick_lanes),
        .grant     (w_pick_grant),
        .count     (w_pick_count),
        .next_ptr  (w_pick_next_ptr)
    );

    // Freeze FSM next-state; grants are allowed whenever the next state is S_RUN
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:    if (freeze)  w_state_nxt = S_FREEZE;
            S_FREEZE: if (!freeze) w_state_nxt = S_RUN;
            default:  w_state_nxt = S_RUN;
        endcase
    end

    assign w_run = (w_state_nxt == S_RUN);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_RUN;
        else     r_state <= w_state_nxt;
    end

    // Registered grants, round-robin pointer and per-thread starvation ages
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dispatch    <= {NUM_ALUS{IDLE_TID}};
            r_grant       <= '0;
            r_issue_count <= '0;
            r_rr_ptr      <= '0;
            r_age         <= '0;
        end else if (w_run) begin
            r_dispatch    <= w_pick_lanes;
            r_grant       <= w_pick_grant;
            r_issue_count <= w_pick_count;
            r_rr_ptr      <= w_pick_next_ptr;
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (!thread_valid[t] || w_pick_grant[t])
                    r_age[t] <= '0;
                else if (w_elig[t] && (r_age[t] != C_AGE_MAX))
                    r_age[t] <= r_age[t] + AGE_W'(1);
            end
        end else begin
            r_dispatch    <= {NUM_ALUS{IDLE_TID}};
            r_grant       <= '0;
            r_issue_count <= '0;
        end
    end

    assign dispatch_threads = r_dispatch;
    assign grant_thread     = r_grant;
    assign issue_count      = r_issue_count;

`ifdef PERF_CNT_EN
    logic [31:0]      r_perf_cycles;
    logic [31:0]      r_perf_issued;
    logic [CNT_W-1:0] w_issue_nxt;
    logic [32:0]      w_issued_sum;

    // Accumulate the count that is being loaded into issue_count this edge
    assign w_issue_nxt  = w_run ? w_pick_count : '0;
    assign w_issued_sum = {1'b0, r_perf_issued} + 33'(w_issue_nxt);

    // Saturating run-cycle and issued-instruction counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_cycles <= '0;
            r_perf_issued <= '0;
        end else begin
            if ((r_state == S_RUN) && (r_perf_cycles != '1))
                r_perf_cycles <= r_perf_cycles + 32'd1;
            r_perf_issued <= w_issued_sum[32] ? '1 : w_issued_sum[31:0];
        end
    end

    assign perf_cycles = r_perf_cycles;
    assign perf_issued = r_perf_issued;
`endif

endmodule
`default_nettype wire

// File: tb/tb_thread_dispatch_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_thread_dispatch_scheduler
// Description : Directed self-checking bench for thread_dispatch_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_thread_dispatch_scheduler;
    import thread_dispatch_scheduler_pkg::*;

    logic                           clk = 1'b0;
    logic                           rst;
    logic [NUM_THREADS-1:0]         thread_valid;
    logic [NUM_THREADS-1:0]         thread_hold;
    logic [NUM_ALUS-1:0]            alu_avail;
    logic                           freeze;
    logic [NUM_ALUS-1:0][TID_W-1:0] dispatch_threads;
    logic [NUM_THREADS-1:0]         grant_thread;
    logic [CNT_W-1:0]               issue_count;
`ifdef PERF_CNT_EN
    logic [31:0]                    perf_cycles;
    logic [31:0]                    perf_issued;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    thread_dispatch_scheduler #(.STARVE_LIMIT(7)) dut (
        .clk              (clk),
        .rst              (rst),
        .thread_valid     (thread_valid),
        .thread_hold      (thread_hold),
        .alu_avail        (alu_avail),
        .freeze           (freeze),
        .dispatch_threads (dispatch_threads),
        .grant_thread     (grant_thread),
        .issue_count      (issue_count)
`ifdef PERF_CNT_EN
        ,
        .perf_cycles      (perf_cycles),
        .perf_issued      (perf_issued)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pack lane ids {lane2, lane1, lane0}
    function automatic logic [31:0] lanes(input int l0, input int l1, input int l2);
        return 32'({TID_W'(l2), TID_W'(l1), TID_W'(l0)});
    endfunction

    task automatic do_reset();
        rst          = 1'b1;
        thread_valid = '0;
        thread_hold  = '0;
        alu_avail    = '0;
        freeze       = 1'b0;
        step();
        rst          = 1'b0;
    endtask

    initial begin
        int  sum;
        bit  seen;

        // Reset state
        do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_lanes", 32'(dispatch_threads), lanes(4, 4, 4));
        check("rst_grant", 32'(grant_thread), 32'h0);
        check("rst_count", 32'(issue_count), 32'd0);

        // All four eligible, three lanes
        thread_valid = 4'b1111;
        alu_avail    = 3'b111;
        step();
        check("full1_lanes", 32'(dispatch_threads), lanes(0, 1, 2));
        check("full1_grant", 32'(grant_thread), 32'b0111);
        check("full1_count", 32'(issue_count), 32'd3);
        step();
        check("full2_lanes", 32'(dispatch_threads), lanes(3, 4, 4));
        check("full2_grant", 32'(grant_thread), 32'b1000);
        check("full2_count", 32'(issue_count), 32'd1);
        step();
        check("full3_lanes", 32'(dispatch_threads), lanes(0, 1, 2));

        // Single thread: back-to-back block alternates issue
        do_reset();
        thread_valid = 4'b0001;
        alu_avail    = 3'b111;
        for (int i = 0; i < 4; i++) begin
            step();
            check("single_count", 32'(issue_count), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("single_lanes", 32'(dispatch_threads),
                  (i % 2 == 0) ? lanes(0, 4, 4) : lanes(4, 4, 4));
        end

        // Only lane 1 available: threads rotate 0,1,2,3 on lane 1
        do_reset();
        thread_valid = 4'b1111;
        alu_avail    = 3'b010;
        for (int i = 0; i < 4; i++) begin
            step();
            check("lane1_lanes", 32'(dispatch_threads), lanes(4, i, 4));
            check("lane1_grant", 32'(grant_thread), 32'(1 << i));
        end

        // No lanes: nothing issues while thread 2 ages to the promotion limit
        do_reset();
        thread_valid = 4'b0100;
        alu_avail    = 3'b000;
        for (int i = 0; i < 7; i++) begin
            step();
            check("noalu_count", 32'(issue_count), 32'd0);
        end
        // Promoted thread 2 beats round-robin pointer 0
        thread_valid = 4'b0111;
        alu_avail    = 3'b001;
        step();
        check("promote_lanes", 32'(dispatch_threads), lanes(2, 4, 4));
        step();
        check("promote_rr_kept", 32'(dispatch_threads), lanes(0, 4, 4));

        // Contended single lane: thread 2 served within STARVE_LIMIT+1 cycles
        do_reset();
        thread_valid = 4'b0111;
        alu_avail    = 3'b001;
        seen         = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (grant_thread[2]) begin
                seen = 1'b1;
                break;
            end
        end
        check("starve_bound", 32'(seen), 32'd1);

        // Freeze mid-stream for five cycles
        do_reset();
        thread_valid = 4'b1111;
        alu_avail    = 3'b111;
        step();
        check("prefrz_count", 32'(issue_count), 32'd3);
        freeze = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("frz_lanes", 32'(dispatch_threads), lanes(4, 4, 4));
            check("frz_grant", 32'(grant_thread), 32'h0);
        end
        freeze = 1'b0;
        step();
        check("unfrz_lanes", 32'(dispatch_threads), lanes(3, 0, 1));
        check("unfrz_grant", 32'(grant_thread), 32'b1011);

        // Reset and freeze together: reset wins, pointer restarts at 0
        rst    = 1'b1;
        freeze = 1'b1;
        step();
        check("rstfrz_lanes", 32'(dispatch_threads), lanes(4, 4, 4));
        check("rstfrz_count", 32'(issue_count), 32'd0);
        rst    = 1'b0;
        freeze = 1'b0;
        step();
        check("after_rstfrz_lanes", 32'(dispatch_threads), lanes(0, 1, 2));

        // Reset during active grants, then ten cycles of full issue
        rst = 1'b1;
        step();
        check("midrst_lanes", 32'(dispatch_threads), lanes(4, 4, 4));
        check("midrst_grant", 32'(grant_thread), 32'h0);
`ifdef PERF_CNT_EN
        check("midrst_pcyc", perf_cycles, 32'd0);
        check("midrst_piss", perf_issued, 32'd0);
`endif
        rst = 1'b0;
        sum = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("run10_count", 32'(issue_count), (i % 2 == 0) ? 32'd3 : 32'd1);
            sum += int'(issue_count);
        end
        check("run10_sum", 32'(sum), 32'd20);
`ifdef PERF_CNT_EN
        check("perf_cycles", perf_cycles, 32'd10);
        check("perf_issued", perf_issued, 32'd20);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
